// File: rtl/param_def.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : param_def (package)
// Purpose  : Shared constants, FSM state type and constraint-length helpers
//            for the Viterbi traceback block.
// Revision : 1.0 - initial release
// ============================================================================
package param_def;

  // Default maximum number of radix-4 steps held per frame
  localparam int TB_DEPTH_DEF      = 64;
  // Widest supported trellis state (K=9 -> m=8)
  localparam int MAX_STATE_REG_NUM = 8;
  localparam int MAX_STATE_NUM     = 1 << MAX_STATE_REG_NUM;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_TRACE  = 2'd1,
    ST_OUTPUT = 2'd2
  } tb_state_e;

  // K = 3 + 2*constr_len, m = K-1; returns a mask of the low m state bits
  function automatic logic [MAX_STATE_REG_NUM-1:0] state_mask(input logic [1:0] constr_len);
    logic [MAX_STATE_REG_NUM-1:0] mask;
    case (constr_len)
      2'd0:    mask = 8'h03;
      2'd1:    mask = 8'h0F;
      2'd2:    mask = 8'h3F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // Shift that places a 2-bit decision into the top of an m-bit state (m-2)
  function automatic logic [2:0] top_shift(input logic [1:0] constr_len);
    return {constr_len, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/surv_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : surv_mem
// Purpose  : Survivor-decision storage, one full decision vector per radix-4
//            step. Synchronous write, combinational 2-bit read by
//            (step, state).
// Revision : 1.0 - initial release
// ============================================================================
module surv_mem
  import param_def::*;
#(
  parameter int TB_DEPTH = TB_DEPTH_DEF,
  parameter int PTR_W    = $clog2(TB_DEPTH)
) (
  input  logic                                clk,
  input  logic                                wr_en,
  input  logic [PTR_W-1:0]                    wr_addr,
  input  logic [MAX_STATE_NUM-1:0][1:0]       wr_data,
  input  logic [PTR_W-1:0]                    rd_addr,
  input  logic [MAX_STATE_REG_NUM-1:0]        rd_state,
  output logic [1:0]                          rd_dec
);

  logic [MAX_STATE_NUM-1:0][1:0] mem [TB_DEPTH];

  // Store one step's decision vector; contents are never cleared
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_dec = mem[rd_addr][rd_state];

endmodule
`default_nettype wire

// File: rtl/viterbi_traceback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : viterbi_traceback
// Purpose  : Radix-4 Viterbi traceback. Collects survivor decisions for a
//            frame, walks them backwards from the supplied end state, then
//            streams the decoded bits out oldest-first with valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module viterbi_traceback
  import param_def::*;
#(
  parameter int TB_DEPTH = TB_DEPTH_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en_tb,
  input  logic [1:0]                          i_constr_len,
  input  logic                                i_surv_valid,
  input  logic [MAX_STATE_NUM-1:0][1:0]       i_surv,
  input  logic                                i_frame_end,
  input  logic [MAX_STATE_REG_NUM-1:0]        i_end_state,
  output logic                                o_surv_ready,
  output logic                                o_dec_bit,
  output logic                                o_dec_valid,
  input  logic                                i_dec_ready,
  output logic                                o_dec_last
);

  localparam int PTR_W = $clog2(TB_DEPTH);
  localparam int IDX_W = PTR_W + 1;   // indexes 2*TB_DEPTH decoded bits
  localparam int CNT_W = PTR_W + 1;   // holds 1..TB_DEPTH steps

  tb_state_e                     state;
  tb_state_e                     state_nxt;
  logic [PTR_W-1:0]              wr_ptr;
  logic [PTR_W-1:0]              rd_ptr;
  logic [IDX_W-1:0]              out_idx;
  logic [CNT_W-1:0]              nsteps;
  logic [MAX_STATE_REG_NUM-1:0]  cur_state;
  logic [MAX_STATE_REG_NUM-1:0]  cur_state_nxt;
  logic [1:0]                    constr_len_q;
  logic [2*TB_DEPTH-1:0]         dec_buf;
  logic [1:0]                    dec;
  logic [CNT_W:0]                last_idx;

  logic accept;
  logic close_frame;
  logic trace_step;
  logic trace_done;
  logic out_active;
  logic out_fire;
  logic last_hit;

  // Handshake and sequencing qualifiers; everything is gated by en_tb
  assign accept      = (state == ST_FILL) && en_tb && i_surv_valid;
  assign close_frame = accept && (i_frame_end || (wr_ptr == PTR_W'(TB_DEPTH - 1)));
  assign trace_step  = (state == ST_TRACE) && en_tb;
  assign trace_done  = trace_step && (rd_ptr == '0);
  assign out_active  = (state == ST_OUTPUT) && en_tb;
  assign out_fire    = out_active && i_dec_ready;
  assign last_idx    = {nsteps, 1'b0} - {{CNT_W{1'b0}}, 1'b1};
  assign last_hit    = ({1'b0, out_idx} == last_idx);

  // Previous state: shift out the two decoded bits, insert the decision on top
  assign cur_state_nxt = ((cur_state >> 2)
                         | (MAX_STATE_REG_NUM'(dec) << top_shift(constr_len_q)))
                         & state_mask(constr_len_q);

  surv_mem #(
    .TB_DEPTH (TB_DEPTH),
    .PTR_W    (PTR_W)
  ) u_surv_mem (
    .clk      (clk),
    .wr_en    (accept),
    .wr_addr  (wr_ptr),
    .wr_data  (i_surv),
    .rd_addr  (rd_ptr),
    .rd_state (cur_state),
    .rd_dec   (dec)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL:   if (close_frame)          state_nxt = ST_TRACE;
      ST_TRACE:  if (trace_done)           state_nxt = ST_OUTPUT;
      ST_OUTPUT: if (out_fire && last_hit) state_nxt = ST_FILL;
      default:                             state_nxt = ST_FILL;
    endcase
  end

  // FSM outputs; bit and last are forced low whenever valid is low
  always_comb begin
    o_surv_ready = 1'b0;
    o_dec_valid  = 1'b0;
    o_dec_bit    = 1'b0;
    o_dec_last   = 1'b0;
    if (state == ST_FILL) begin
      o_surv_ready = en_tb;
    end
    if (out_active) begin
      o_dec_valid = 1'b1;
      o_dec_bit   = dec_buf[out_idx];
      o_dec_last  = last_hit;
    end
  end

  // Pointers, step count and traceback state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      out_idx      <= '0;
      nsteps       <= '0;
      cur_state    <= '0;
      constr_len_q <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (close_frame) begin
        nsteps       <= {1'b0, wr_ptr} + CNT_W'(1);
        cur_state    <= i_end_state & state_mask(i_constr_len);
        rd_ptr       <= wr_ptr;
        constr_len_q <= i_constr_len;
      end
      if (trace_step) begin
        cur_state <= cur_state_nxt;
        rd_ptr    <= rd_ptr - PTR_W'(1);
      end
      if (out_fire) begin
        if (last_hit) begin
          out_idx <= '0;
          wr_ptr  <= '0;
        end else begin
          out_idx <= out_idx + IDX_W'(1);
        end
      end
    end
  end

  // Decoded-bit buffer: the earlier bit of each pair lands at the even index
  always_ff @(posedge clk) begin
    if (trace_step) begin
      dec_buf[{rd_ptr, 1'b0} +: 2] <= {cur_state[0], cur_state[1]};
    end
  end

endmodule
`default_nettype wire

// File: doc/viterbi_traceback.md
VITERBI_TRACEBACK -- requirements
Module: viterbi_traceback

Interface
REQ-001 Parameter TB_DEPTH, default 64: maximum radix-4 steps per frame (maximum 128 decoded bits).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 en_tb  input  1  block enable; low freezes the block.
REQ-005 i_constr_len  input  2  K = 3 + 2*i_constr_len, giving state width m = K-1 of 2, 4, 6 or 8 bits.
REQ-006 i_surv_valid  input  1  survivor-decision vector for one radix-4 step is present.
REQ-007 i_surv  input  [MAX_STATE_NUM-1:0][1:0]  2-bit predecessor decision d per state.
REQ-008 i_frame_end  input  1  qualifies the current step as the last step of the frame.
REQ-009 i_end_state  input  MAX_STATE_REG_NUM  traceback start state, sampled with the frame-end step.
REQ-010 o_surv_ready  output  1  block accepts a step this cycle.
REQ-011 o_dec_bit  output  1  decoded bit.
REQ-012 o_dec_valid  output  1  o_dec_bit is valid.
REQ-013 i_dec_ready  input  1  sink accepts o_dec_bit.
REQ-014 o_dec_last  output  1  marks the final decoded bit of a frame (qualified by o_dec_valid).

Function
REQ-015 The FSM SHALL have exactly three states: FILL, TRACE and OUTPUT.
REQ-016 In FILL, o_surv_ready SHALL equal en_tb; a step is accepted when i_surv_valid && o_surv_ready.
- Each accepted step is written to survivor memory at wr_ptr, which then increments.
REQ-017 When a step is accepted with i_frame_end=1, or at wr_ptr=TB_DEPTH-1:
- nsteps := wr_ptr+1;
- cur_state := i_end_state masked to m bits;
- rd_ptr := wr_ptr;
- next state is TRACE.
REQ-018 In TRACE, one step SHALL be processed per cycle:
- decoded pair {cur_state[1], cur_state[0]} is stored at bit positions 2*rd_ptr and 2*rd_ptr+1; cur_state[1] is the earlier bit;
- d = mem[rd_ptr][cur_state];
- cur_state := ((cur_state >> 2) | (d << (m-2))) masked to m bits;
- rd_ptr decrements;
- after processing rd_ptr=0, next state is OUTPUT.
REQ-019 In OUTPUT, o_dec_valid=1 and o_dec_bit = bit[out_idx], with out_idx starting at 0 and advancing only on o_dec_valid && i_dec_ready.
REQ-020 o_dec_last SHALL be 1 when out_idx = 2*nsteps-1.
- On acceptance of that bit: wr_ptr := 0, next state is FILL.
REQ-021 o_dec_bit and o_dec_last SHALL remain stable while o_dec_valid=1 and i_dec_ready=0.
REQ-022 Latency: frame-end step accepted in cycle T gives the first o_dec_valid in cycle T+nsteps+1.
REQ-023 In TRACE and OUTPUT, o_surv_ready SHALL be 0; i_surv_valid is ignored.
REQ-024 When en_tb=0:
- FSM, pointers and memory hold their values;
- o_surv_ready=0 and o_dec_valid=0;
- operation resumes unchanged when en_tb returns high.
REQ-025 i_constr_len SHALL be held constant within a frame; the value sampled at frame end governs TRACE.
REQ-026 A single-step frame (frame end on the first step) SHALL yield exactly 2 output bits.

Reset
REQ-027 On rst=0, regardless of state:
- FSM enters FILL;
- wr_ptr, rd_ptr, out_idx, nsteps and cur_state are 0;
- o_dec_valid, o_dec_bit and o_dec_last are 0; o_surv_ready follows REQ-016.
REQ-028 Reset SHALL discard any partial frame; survivor memory contents need not be cleared.

Structure
REQ-029 TB_DEPTH default, the FSM state enum and the K-to-m mapping SHALL live in the shared param_def package, alongside MAX_STATE_NUM and MAX_STATE_REG_NUM.
REQ-030 Survivor storage SHALL be one sub-module, surv_mem:
- TB_DEPTH x (MAX_STATE_NUM*2) bits;
- synchronous write, combinational read of the 2-bit entry addressed by (rd_ptr, cur_state).
REQ-031 The decoded-bit buffer SHALL be a 2*TB_DEPTH-bit register array inside viterbi_traceback.

Verification
REQ-032 K=3, 4 steps, all decisions 0, i_end_state=0 -> 8 zero bits, o_dec_last on the 8th bit, first valid 5 cycles after frame end.
REQ-033 K=3, 2 steps:
- step0 mem[0][2]=0; step1 mem[1][3]=2'b10; i_end_state=3;
- required output 1,0,1,1.
REQ-034 K=9, 64 steps with no i_frame_end -> auto-close at step 63, 128 bits output, o_surv_ready=0 throughout TRACE/OUTPUT.
REQ-035 i_dec_ready held low for 5 cycles at out_idx=3 -> o_dec_bit and o_dec_last stable, no bit lost or duplicated.
REQ-036 en_tb low for 3 cycles mid-TRACE, then rst pulse mid-OUTPUT:
- en_tb low: output identical to the uninterrupted run, delayed 3 cycles;
- rst pulse: o_dec_valid=0 immediately, FILL with o_surv_ready=1 after release.
